booth_iter_sequencer: RTL and testbench

Parametrised iteration sequencer for the Booth multiplier datapath. It generalises the fixed "count reached 14" comparator into a programmable iteration controller. Per operation it:
- counts 1..MAX_ITER add/shift steps,
- produces a registered look-ahead `last` flag,
- supports stall and abort,
- signals completion with a one-cycle `done` pulse under a start/done handshake.

It sits between the multiplier's top-level control and the add/shift datapath, and replaces the free-running counter plus comparator pair.

---
 rtl/booth_iter_sequencer.sv | 106 ++++++++++
 tb/tb_booth_iter_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/booth_iter_sequencer.sv
// Programmable iteration controller for the Booth add/shift datapath.
// Counts 1..MAX_ITER steps per operation with stall/abort and a start/done handshake.
module booth_iter_sequencer #(
    parameter int MAX_ITER = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] iter_cnt,
    input  logic             stall,
    input  logic             abort,
    output logic             busy,
    output logic             step_en,
    output logic [CNT_W-1:0] step_idx,
    output logic             last,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] term;
    logic             load;
    logic             abort_run;

    // Zero and out-of-range requests fall back to a full-width operation.
    function automatic logic [CNT_W-1:0] clamp_iter(input logic [CNT_W-1:0] c);
        if ((c == '0) || (c > MAX_C))
            return MAX_C;
        return c;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = RUN;
            end
            RUN: begin
                if (abort)
                    state_nxt = IDLE;
                else if (stall)
                    state_nxt = RUN;
                else if (last)
                    state_nxt = DONE;
                else
                    state_nxt = RUN;
            end
            DONE: begin
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == RUN);
        done    = (state == DONE);
        step_en = (state == RUN) & ~stall & ~abort;
    end

    assign load      = start & ((state == IDLE) | (state == DONE));
    assign abort_run = (state == RUN) & abort;

    // last is computed one step ahead so the final step needs no compare on step_idx.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            term     <= MAX_C;
            step_idx <= '0;
            last     <= 1'b0;
        end else if (load) begin
            term     <= clamp_iter(iter_cnt);
            step_idx <= '0;
            last     <= (clamp_iter(iter_cnt) == ONE_C);
        end else if (abort_run) begin
            step_idx <= '0;
            last     <= 1'b0;
        end else if (step_en) begin
            if (last) begin
                step_idx <= '0;
                last     <= 1'b0;
            end else begin
                step_idx <= step_idx + ONE_C;
                last     <= ((step_idx + ONE_C) == (term - ONE_C));
            end
        end
    end

endmodule

// File: tb/tb_booth_iter_sequencer.sv
// Randomized and directed bench for booth_iter_sequencer against an operation-level model.
module tb_booth_iter_sequencer;

    localparam int MAX_ITER = 16;
    localparam int CNT_W    = 5;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] iter_cnt;
    logic             stall;
    logic             abort;
    logic             busy;
    logic             step_en;
    logic [CNT_W-1:0] step_idx;
    logic             last;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: is an operation running, how many steps it has taken, its length, done pulse.
    int m_run  = 0;
    int m_idx  = 0;
    int m_term = MAX_ITER;
    int m_done = 0;

    booth_iter_sequencer #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .iter_cnt (iter_cnt),
        .stall    (stall),
        .abort    (abort),
        .busy     (busy),
        .step_en  (step_en),
        .step_idx (step_idx),
        .last     (last),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        int exp_en;
        int exp_last;
        exp_en   = (m_run != 0 && !stall && !abort) ? 1 : 0;
        exp_last = (m_run != 0 && m_idx == m_term - 1) ? 1 : 0;
        chk("busy",     int'(busy),     m_run);
        chk("step_en",  int'(step_en),  exp_en);
        chk("step_idx", int'(step_idx), m_idx);
        chk("last",     int'(last),     exp_last);
        chk("done",     int'(done),     m_done);
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_idx  = 0;
        m_term = MAX_ITER;
        m_done = 0;
    endtask

    task automatic model_update();
        int n_done;
        int c;
        n_done = 0;
        if (m_run != 0) begin
            if (abort) begin
                m_run = 0;
                m_idx = 0;
            end else if (!stall) begin
                if (m_idx == m_term - 1) begin
                    m_run  = 0;
                    m_idx  = 0;
                    n_done = 1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end
        end else if (start) begin
            c      = int'(iter_cnt);
            m_term = (c == 0 || c > MAX_ITER) ? MAX_ITER : c;
            m_run  = 1;
            m_idx  = 0;
        end
        m_done = n_done;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        if (!reset)
            model_reset();
        else
            model_update();
        #1;
    endtask

    task automatic drive(input logic s, input int cnt, input logic st, input logic ab);
        start    = s;
        iter_cnt = CNT_W'(cnt);
        stall    = st;
        abort    = ab;
        run_cycle();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        iter_cnt = '0;
        stall    = 1'b0;
        abort    = 1'b0;
        model_reset();

        for (int i = 0; i < 3; i++)
            run_cycle();
        reset = 1'b1;
        idle_cycles(1);

        // Default full-length run.
        drive(1'b1, 16, 1'b0, 1'b0);
        idle_cycles(19);

        // Single iteration, then clamped lengths.
        drive(1'b1, 1, 1'b0, 1'b0);
        idle_cycles(3);
        drive(1'b1, 0, 1'b0, 1'b0);
        idle_cycles(19);
        drive(1'b1, 20, 1'b0, 1'b0);
        idle_cycles(19);

        // Stall in cycles 2-3 of a 4-step operation.
        drive(1'b1, 4, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        idle_cycles(6);

        // Abort with stall, plus an ignored start mid-run.
        drive(1'b1, 8, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 3, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b1);
        idle_cycles(4);

        // Ignored start mid-run must not shorten the operation.
        drive(1'b1, 6, 1'b0, 1'b0);
        drive(1'b1, 2, 1'b0, 1'b0);
        idle_cycles(8);

        // Back-to-back with start held high.
        for (int i = 0; i < 6; i++)
            drive(1'b1, 2, 1'b0, 1'b0);
        idle_cycles(3);

        // Asynchronous reset in the middle of a run.
        drive(1'b1, 10, 1'b0, 1'b0);
        idle_cycles(4);
        reset = 1'b0;
        #1;
        chk("async_busy",     int'(busy),     0);
        chk("async_last",     int'(last),     0);
        chk("async_step_idx", int'(step_idx), 0);
        chk("async_done",     int'(done),     0);
        model_reset();
        idle_cycles(2);
        reset = 1'b1;
        idle_cycles(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 31)),
                  ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 4)  ? 1'b1 : 1'b0);
        end
        idle_cycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
